vc_input_buffer: RTL

//  Per-port ingress buffer sitting directly upstream of the switch crossbar. Accepts flits from one link,

---
 rtl/vc_input_buffer_pkg.sv | 16 +
 rtl/vc_input_buffer_if.sv | 30 +++
 rtl/vc_input_buffer_fifo.sv | 54 +++++
 rtl/vc_input_buffer.sv | 60 ++++++
 4 files changed

// File: rtl/vc_input_buffer_pkg.sv
// rtl/vc_input_buffer_pkg.sv - shared flit types and defaults for the VC input buffer
package vc_input_buffer_pkg;

  localparam int NUM_VCS = 2;
  // One spare VC bit so out-of-range VC ids on the link remain representable.
  localparam int VC_W    = 2;
  localparam int DATA_W  = 16;

  typedef logic [VC_W-1:0] vc_id_t;

  typedef struct packed {
    vc_id_t              vc;
    logic [DATA_W-1:0]   data;
  } flit_t;

endpackage

// File: rtl/vc_input_buffer_if.sv
// rtl/vc_input_buffer_if.sv - link/switch-facing bundle of the VC input buffer
import vc_input_buffer_pkg::*;

interface vc_input_buffer_if #(
  parameter int N = NUM_VCS
);

  flit_t          flit_in;
  logic           data_ready_in;
  logic [N-1:0]   pop;
  flit_t          head_flit [N];
  logic [N-1:0]   head_valid;
  logic [N-1:0]   buffer_available;
  logic [N-1:0]   credit_granted;
  logic           overflow_err;
  logic           underflow_err;

  modport master (
    output flit_in, data_ready_in, pop,
    input  head_flit, head_valid, buffer_available, credit_granted,
    input  overflow_err, underflow_err
  );

  modport slave (
    input  flit_in, data_ready_in, pop,
    output head_flit, head_valid, buffer_available, credit_granted,
    output overflow_err, underflow_err
  );

endinterface

// File: rtl/vc_input_buffer_fifo.sv
// rtl/vc_input_buffer_fifo.sv - single-VC synchronous flit FIFO
import vc_input_buffer_pkg::*;

module vc_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  flit_t                    din,
  output flit_t                    head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_drop,
  output logic                     pop_err,
  output logic                     pop_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  flit_t           mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            full;
  logic            push_ok;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign pop_ok    = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop_ok);
  assign push_drop = push && !push_ok;
  assign pop_err   = pop && empty;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vc_input_buffer.sv
// rtl/vc_input_buffer.sv - per-port ingress buffer: VC demux, per-VC FIFOs, credit return
import vc_input_buffer_pkg::*;

module vc_input_buffer #(
  parameter int NUM_VCS = vc_input_buffer_pkg::NUM_VCS,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  vc_input_buffer_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_VCS-1:0]  push;
  logic [NUM_VCS-1:0]  empty;
  logic [NUM_VCS-1:0]  push_drop;
  logic [NUM_VCS-1:0]  pop_err;
  logic [NUM_VCS-1:0]  pop_ok;
  logic [CW-1:0]       count [NUM_VCS];
  logic                bad_vc;

  assign bad_vc = bus.data_ready_in && (int'(bus.flit_in.vc) >= NUM_VCS);

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign push[v] = bus.data_ready_in && (int'(bus.flit_in.vc) == v);

    vc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .push      (push[v]),
      .pop       (bus.pop[v]),
      .din       (bus.flit_in),
      .head      (bus.head_flit[v]),
      .empty     (empty[v]),
      .count     (count[v]),
      .push_drop (push_drop[v]),
      .pop_err   (pop_err[v]),
      .pop_ok    (pop_ok[v])
    );

    assign bus.buffer_available[v] = (count[v] != CW'(DEPTH));
  end

  assign bus.head_valid = ~empty;

  // Credits mirror accepted pops one cycle later; reset never emits a credit.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bus.credit_granted <= '0;
      bus.overflow_err   <= 1'b0;
      bus.underflow_err  <= 1'b0;
    end else begin
      bus.credit_granted <= pop_ok;
      bus.overflow_err   <= bus.overflow_err | (|push_drop) | bad_vc;
      bus.underflow_err  <= bus.underflow_err | (|pop_err);
    end
  end

endmodule
